// File: rtl/sdram_burst_unpack_dma.sv
// sdram_burst_unpack_dma: burst-reads SDRAM words into a FIFO and unpacks them into pixel RAM writes.
// Define SDRAM_DMA_ABORT_EN to add the abort input and aborted flag.
module sdram_burst_unpack_dma #(
    parameter int ADDR_W     = 29,
    parameter int DATA_W     = 64,
    parameter int LANE_W     = 16,
    parameter int PIX_W      = 12,
    parameter int DST_AW     = 10,
    parameter int BURST_MAX  = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] begin_address,
    input  logic [31:0]       word_count,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic [7:0]        avm_burstcount,
    input  logic              avm_waitrequest,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_readdatavalid,
    output logic [DST_AW-1:0] dst_address,
    output logic [PIX_W-1:0]  dst_data,
    output logic              dst_we,
    input  logic              dst_ready,
    output logic              dst_clk
`ifdef SDRAM_DMA_ABORT_EN
    ,
    input  logic              abort,
    output logic              aborted
`endif
);
    localparam int LANES = DATA_W / LANE_W;
    localparam int LW = LANES > 1 ? $clog2(LANES) : 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] PUSH_LIMIT = CW'(FIFO_DEPTH - BURST_MAX);
    localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, RECV, DRAIN} state_t;

    state_t            state;
    logic [31:0]       remaining;
    logic [7:0]        pending;
    logic [7:0]        next_bc;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] word;
    logic [LW-1:0]     lane;
    logic              held, push, pop, lane_done, start_ok, flush, drop;

`ifdef SDRAM_DMA_ABORT_EN
    assign flush = abort && busy;
    assign drop  = aborted || flush;
    always_ff @(posedge clk)
        aborted <= rst ? 1'b0 : start_ok ? 1'b0 : flush ? 1'b1 : aborted;
`else
    assign flush = 1'b0;
    assign drop  = 1'b0;
`endif

    assign dst_clk   = clk;
    assign start_ok  = start && state == IDLE;
    // Beats are only accepted while a burst is outstanding; anything else is stray.
    assign push      = state == RECV && avm_readdatavalid && !drop;
    assign lane_done = held && dst_ready && lane == LAST_LANE;
    assign pop       = cnt != '0 && (!held || lane_done);
    assign next_bc   = remaining >= 32'(BURST_MAX) ? 8'(BURST_MAX) : remaining[7:0];
    assign dst_we    = held;
    assign dst_data  = word[lane*LANE_W +: PIX_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            avm_read       <= 1'b0;
            avm_address    <= '0;
            avm_burstcount <= '0;
            remaining      <= '0;
            pending        <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    avm_address <= begin_address;
                    remaining   <= word_count;
                    busy        <= word_count != 0;
                    done        <= word_count == 0;
                    state       <= word_count != 0 ? ISSUE : IDLE;
                end
                ISSUE: if (avm_read) begin
                    if (!avm_waitrequest) begin
                        avm_read    <= 1'b0;
                        avm_address <= avm_address + ADDR_W'(avm_burstcount);
                        remaining   <= remaining - 32'(avm_burstcount);
                        pending     <= avm_burstcount;
                        state       <= RECV;
                    end
                end else if (drop) begin
                    state <= DRAIN;
                end else if (cnt <= PUSH_LIMIT) begin
                    avm_read       <= 1'b1;
                    avm_burstcount <= next_bc;
                end
                RECV: if (avm_readdatavalid) begin
                    pending <= pending - 8'd1;
                    if (pending == 8'd1) state <= (remaining != 0 && !drop) ? ISSUE : DRAIN;
                end
                DRAIN: if (cnt == '0 && (!held || lane_done)) begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= avm_readdata;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end

    // Popping on the last accepted lane keeps the pixel stream bubble-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            held        <= 1'b0;
            lane        <= '0;
            word        <= '0;
            dst_address <= '0;
        end else begin
            if (start_ok) dst_address <= '0;
            else if (held && dst_ready) dst_address <= dst_address + DST_AW'(1);
            if (flush) begin
                held <= 1'b0;
            end else if (pop) begin
                word <= mem[rd_ptr];
                lane <= '0;
                held <= 1'b1;
            end else if (lane_done) begin
                held <= 1'b0;
            end else if (held && dst_ready) begin
                lane <= lane + LW'(1);
            end
        end
    end
endmodule

// File: tb/tb_sdram_burst_unpack_dma.sv
// tb_sdram_burst_unpack_dma: directed scenarios against an Avalon burst slave model,
// with burst and pixel scoreboards filled at start and drained by the monitor.
module tb_sdram_burst_unpack_dma;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [28:0] begin_address = '0;
    logic [31:0] word_count = '0;
    logic        busy, done, avm_read, dst_we, dst_clk;
    logic [28:0] avm_address;
    logic [7:0]  avm_burstcount;
    logic        avm_waitrequest = 1'b0, avm_readdatavalid = 1'b0, dst_ready = 1'b1;
    logic [63:0] avm_readdata = '0;
    logic [9:0]  dst_address;
    logic [11:0] dst_data;

    typedef struct packed {logic [9:0] a; logic [11:0] d;} pix_t;

    pix_t        pix_q[$];
    logic [36:0] burst_q[$];
    logic [28:0] beat_q[$];
    pix_t        e;
    int          errors = 0, checks = 0, cyc = 0;
    bit          active = 0, done_seen = 0, rnd_ready = 0, prev_wait = 0, prev_hold = 0;
    int          stall_burst = -1, stall_left = 0, burst_idx = 0, stalls = 0;
    int          beats_seen = 0, last_wr = 0, writes = 0;
    logic [36:0] prev_req;
    logic [21:0] prev_pix;

    always #5 clk = ~clk;

    sdram_burst_unpack_dma dut (
        .clk(clk), .rst(rst), .start(start), .begin_address(begin_address),
        .word_count(word_count), .busy(busy), .done(done), .avm_address(avm_address),
        .avm_read(avm_read), .avm_burstcount(avm_burstcount),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid), .dst_address(dst_address),
        .dst_data(dst_data), .dst_we(dst_we), .dst_ready(dst_ready), .dst_clk(dst_clk)
    );

    // Lane k of word a: 4 filler bits above a 12-bit pixel that differs per lane and word.
    function automatic logic [63:0] mem_word(input logic [28:0] a);
        logic [63:0] w;
        for (int k = 0; k < 4; k++)
            w[k*16 +: 16] = {4'(k + 9), 12'(a * 29'd4 + 29'(k)) ^ 12'h5A3};
        return w;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        dst_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (avm_read && burst_idx == stall_burst && stall_left > 0) begin
            avm_waitrequest = 1'b1;
            stall_left--;
            stalls++;
        end else avm_waitrequest = 1'b0;
        if (!rst && prev_wait)
            check("req_held", {avm_read, avm_address, avm_burstcount}, {1'b1, prev_req});
        if (!rst && prev_hold)
            check("dst_held", {dst_we, dst_address, dst_data}, {1'b1, prev_pix});
        prev_wait = !rst && avm_read && avm_waitrequest;
        prev_req  = {avm_address, avm_burstcount};
        prev_hold = !rst && dst_we && !dst_ready;
        prev_pix  = {dst_address, dst_data};
        if (beat_q.size() > 0) begin
            avm_readdatavalid = 1'b1;
            avm_readdata = mem_word(beat_q.pop_front());
            beats_seen++;
        end else begin
            avm_readdatavalid = 1'b0;
            avm_readdata = '0;
        end
        if (!rst && avm_read && !avm_waitrequest) begin
            if (burst_q.size() == 0) check("extra_burst", avm_read, 1'b0);
            else check("burst", {avm_address, avm_burstcount}, burst_q.pop_front());
            for (int i = 0; i < int'(avm_burstcount); i++) beat_q.push_back(avm_address + 29'(i));
            burst_idx++;
        end
        if (!rst && dst_we && dst_ready) begin
            if (pix_q.size() == 0) check("extra_write", dst_we, 1'b0);
            else begin
                e = pix_q.pop_front();
                check("pixel", {dst_address, dst_data}, e);
            end
            last_wr = cyc;
            writes++;
        end
        if (!rst && done) begin
            if (!active) check("spurious_done", done, 1'b0);
            else begin
                if (writes > 0) check("done_latency", 64'(cyc - last_wr), 64'd1);
                done_seen = 1;
                active = 0;
            end
        end
    end

    task automatic run(input logic [28:0] a, input int n, input int budget);
        int rem, b;
        logic [63:0] w;
        rem = n;
        while (rem > 0) begin
            b = rem > 8 ? 8 : rem;
            burst_q.push_back({a + 29'(n - rem), 8'(b)});
            rem -= b;
        end
        for (int i = 0; i < 4 * n; i++) begin
            w = mem_word(a + 29'(i / 4));
            pix_q.push_back(pix_t'({10'(i), w[(i % 4) * 16 +: 12]}));
        end
        writes = 0;
        done_seen = 0;
        active = 1;
        @(posedge clk); #2;
        begin_address = a;
        word_count = n;
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        for (int t = 0; t < budget && !done_seen; t++) begin
            @(posedge clk); #2;
        end
        check("done_seen", done_seen, 1'b1);
        check("pix_left", pix_q.size(), 0);
        check("burst_left", burst_q.size(), 0);
        check("busy_end", busy, 1'b0);
        check("dst_addr_end", dst_address, 10'(4 * n));
        pix_q.delete();
        burst_q.delete();
        active = 0;
    endtask

    initial begin
        int b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_ctrl", {busy, done, avm_read, dst_we}, 4'b0);
        check("rst_avm", {avm_address, avm_burstcount}, 37'b0);
        check("rst_dst", {dst_address, dst_data}, 22'b0);
        rst = 1'b0;
        run(29'h100, 2, 200);
        run(29'h2000, 20, 600);
        burst_idx = 0;
        stall_burst = 1;
        stall_left = 5;
        stalls = 0;
        run(29'h2000, 20, 600);
        check("stall_cycles", stalls, 5);
        stall_burst = -1;
        rnd_ready = 1;
        run(29'h4000, 64, 3000);
        rnd_ready = 0;
        run(29'h0, 0, 20);
        run(29'h8000, 300, 5000);
        b0 = beats_seen;
        burst_q.push_back({29'h300, 8'd8});
        burst_q.push_back({29'h308, 8'd8});
        begin_address = 29'h300;
        word_count = 16;
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        for (int t = 0; t < 50 && beats_seen == b0; t++) begin
            @(posedge clk); #2;
        end
        check("recv_reached", beats_seen > b0, 1'b1);
        rst = 1'b1;
        beat_q.delete();
        burst_q.delete();
        @(posedge clk); #2;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) beat_q.push_back(29'h300 + 29'(i));
        repeat (10) @(posedge clk);
        #2;
        check("stray_consumed", beat_q.size(), 0);
        check("post_rst", {busy, done, avm_read, avm_address, avm_burstcount, dst_we, dst_address, dst_data}, 63'b0);
        run(29'h100, 2, 200);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sdram_burst_unpack_dma.md
Name: sdram_burst_unpack_dma

Overview:
- Parametrised successor to the single-beat SDRAM-to-display-buffer copier.
- Fetches a contiguous region of SDRAM words over an Avalon-MM burst read master and buffers the returned beats in an internal FIFO.
- Unpacks each word into LANES pixels and writes them one per cycle into the LED-matrix distributed RAM, honouring a destination ready signal.
- Sits between the HPS SDRAM port and the matrix scan buffer.

Parameters:
- ADDR_W, 29: SDRAM word-address width.
- DATA_W, 64: SDRAM data width. Must be a multiple of LANE_W.
- LANE_W, 16: bit stride of one pixel lane inside a word. LANES = DATA_W/LANE_W.
- PIX_W, 12: pixel width. Must be <= LANE_W. Pixel k = readdata[k*LANE_W +: PIX_W].
- DST_AW, 10: destination RAM address width.
- BURST_MAX, 8: maximum beats per burst. Power of two, 1..128.
- FIFO_DEPTH, 16: beat FIFO depth. Power of two, >= BURST_MAX.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- start  in  1  pulse; launches transfer when idle
- begin_address  in  ADDR_W  first SDRAM word address, sampled on accepted start
- word_count  in  32  number of SDRAM words, sampled on accepted start
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at completion
- avm_address  out  ADDR_W  burst start address
- avm_read  out  1  read request
- avm_burstcount  out  8  beats in this burst
- avm_waitrequest  in  1  slave stall
- avm_readdata  in  DATA_W  returned beat
- avm_readdatavalid  in  1  beat valid
- dst_address  out  DST_AW  destination pixel address
- dst_data  out  PIX_W  pixel
- dst_we  out  1  write strobe
- dst_ready  in  1  destination accepts write this cycle
- dst_clk  out  1  equals clk

Behaviour:
- Reset values: busy=0, done=0, avm_read=0, avm_address=0, avm_burstcount=0, dst_we=0, dst_address=0, dst_data=0.
- Reset clears the FIFO and all counters.
- Reset mid-transfer aborts the transfer with no done pulse. Stray readdatavalid beats arriving while no burst is outstanding are dropped.

Fetch FSM states:
- IDLE: on start, latch inputs, zero dst_address, set busy. If word_count==0, pulse done next cycle and stay in IDLE. start is ignored while busy.
- ISSUE: entered only when words_remaining>0, no burst is outstanding, and FIFO free slots >= BURST_MAX.
  - Drive avm_read=1 with avm_burstcount = min(BURST_MAX, words_remaining) and the current address.
  - Hold all outputs stable while avm_waitrequest=1.
  - When the request is accepted: advance the address by burstcount, subtract burstcount from words_remaining, load beats_pending=burstcount, go to RECV.
- RECV: push each valid beat into the FIFO and decrement beats_pending. At 0, return to ISSUE if words remain, else go to DRAIN.
- DRAIN: wait until the FIFO is empty and the unpacker is idle. Then pulse done, clear busy, go to IDLE.

Unpacker (runs concurrently with the fetch FSM):
- Pops a FIFO word when its holding register is empty, then presents lanes 0..LANES-1 in order.
- dst_we = 1 whenever a lane is held.
- On dst_we && dst_ready, advance the lane and increment dst_address, modulo 2^DST_AW (wraps silently).
- When dst_ready=0, dst_data, dst_address and dst_we hold stable.
- Throughput with dst_ready=1: one pixel per clk. The next word is popped with no bubble after the last lane.

Timing and ordering:
- First dst_we occurs no earlier than 2 cycles after the first readdatavalid.
- done asserts the cycle after the final pixel write is accepted.
- The FIFO never overflows by construction (issue is gated on free space).
- A simultaneous FIFO push and pop in the same cycle is legal.

Optional Feature:
- Macro: SDRAM_DMA_ABORT_EN.
- When defined:
  - Adds input abort (pulse) and output aborted (1 bit, reset 0).
  - abort while busy: no new bursts are issued, outstanding beats are accepted and discarded, the FIFO and unpacker are flushed and dst_we drops the next cycle.
  - Then done pulses with aborted=1. aborted is cleared on the next accepted start.
  - An avm_read already presented is kept until accepted; Avalon forbids withdrawing it.
- When undefined: no abort port, no aborted port, no flush logic.

Test Plan:
- start, begin_address=0x100, word_count=2, no waitrequest, dst_ready=1 -> one burst with burstcount=2 at 0x100. Writes at addresses 0..7 carry pixels word0[11:0], [27:16], [43:32], [59:48], then the same lanes of word1. done pulses 1 cycle after write 7.
- word_count=20, BURST_MAX=8 -> bursts of 8, 8, 4 at addresses A, A+8, A+16. 80 pixel writes. dst_address ends at 80.
- waitrequest high for 5 cycles on the second burst -> avm_address and avm_burstcount stay stable throughout. Pixel data is unchanged versus the no-stall run.
- dst_ready toggled 1,0,0,1 pseudo-randomly with word_count=64 -> FIFO never exceeds FIFO_DEPTH. No pixel is lost or duplicated. 256 writes total.
- word_count=0 -> no avm_read and done pulses once. Then word_count=300 with DST_AW=10 -> dst_address wraps from 1023 to 0 at pixel 1024 (wrap only; 300 words = 1200 pixels).
- rst asserted mid-RECV, then 3 stray readdatavalid beats -> outputs at reset values, no dst_we, no done. A fresh start then behaves as in scenario 1.
